// File: rtl/ps2_receiver.sv
// PS/2 keyboard line deserialiser: synchronises the raw lines, frames 11-bit
// words on falling PS/2 clock edges and strobes good bytes or frame errors.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit and parity, then publishing or dropping
module ps2_receiver #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iPs2Clk,
   input  logic       iPs2Data,
   output logic [7:0] oData,
   output logic       oFlag,
   output logic       oParityErr,
   output logic       oFrameErr
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic [SYNC_STAGES-1:0] data_sync_q;
   logic                   prev_clk_q;
   state_t                 state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [7:0]             data_q, data_d;
   logic                   flag_q, flag_d;
   logic                   perr_q, perr_d;
   logic                   ferr_q, ferr_d;
   logic                   clk_s, data_s, fe, tmo_hit;

   assign clk_s   = clk_sync_q[SYNC_STAGES-1];
   assign data_s  = data_sync_q[SYNC_STAGES-1];
   assign fe      = prev_clk_q & ~clk_s;
   assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge iClk) begin
      if (iReset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         prev_clk_q  <= 1'b1;
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         tmo_q       <= '0;
         data_q      <= '0;
         flag_q      <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], iPs2Clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], iPs2Data};
         prev_clk_q  <= clk_s;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         tmo_q       <= tmo_d;
         data_q      <= data_d;
         flag_q      <= flag_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      data_d    = data_q;
      flag_d    = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      tmo_d     = (fe || state_q == IDLE) ? '0 : tmo_q + TW'(1);

      // A stalled PS/2 clock mid-frame abandons the frame even if an edge
      // would have arrived in the same cycle; that edge is already too late.
      if (tmo_hit) begin
         state_d = IDLE;
         ferr_d  = 1'b1;
         tmo_d   = '0;
      end else if (fe) begin
         case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               parity_d = data_s;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (!data_s) begin
                  ferr_d = 1'b1;
               end else if (^{shift_q, parity_q} != 1'b1) begin
                  perr_d = 1'b1;
               end else begin
                  data_d = shift_q;
                  flag_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign oData      = data_q;
   assign oFlag      = flag_q;
   assign oParityErr = perr_q;
   assign oFrameErr  = ferr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: table of directed frames, hand-built
// corner sequences and random frames scored against a frame-level model.
module tb_ps2_receiver;

   localparam int TMO  = 200;
   localparam int HALF = 30;

   localparam int K_NONE = 0;
   localparam int K_FLAG = 1;
   localparam int K_PERR = 2;
   localparam int K_FERR = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] o_data;
   logic       o_flag, o_perr, o_ferr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_fe_cyc = 0;
   int width_viol  = 0;
   int onehot_viol = 0;

   typedef struct {
      int         kind;
      logic [7:0] d;
      int         at;
   } ev_t;
   ev_t ev_q[$];

   typedef struct {
      logic [7:0] d;
      logic       bad_par;
      logic       stop;
      int         exp_kind;
      logic [7:0] exp_data;
   } vec_t;
   vec_t vecs[5];

   ps2_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
      .iClk      (clk),
      .iReset    (rst),
      .iPs2Clk   (ps2_clk),
      .iPs2Data  (ps2_data),
      .oData     (o_data),
      .oFlag     (o_flag),
      .oParityErr(o_perr),
      .oFrameErr (o_ferr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic prev_f = 1'b0, prev_p = 1'b0, prev_e = 1'b0;
   always @(negedge clk) begin
      if ((o_flag && prev_f) || (o_perr && prev_p) || (o_ferr && prev_e))
         width_viol++;
      if (int'(o_flag) + int'(o_perr) + int'(o_ferr) > 1) onehot_viol++;
      if (o_flag) ev_q.push_back('{K_FLAG, o_data, cyc});
      if (o_perr) ev_q.push_back('{K_PERR, o_data, cyc});
      if (o_ferr) ev_q.push_back('{K_FERR, o_data, cyc});
      prev_f = o_flag;
      prev_p = o_perr;
      prev_e = o_ferr;
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
      end
   endtask

   // One frame outcome: how many strobes, which kind, and oData afterwards.
   task automatic check_outcome(input string name, input int exp_kind, input logic [7:0] exp_data);
      check({name, " strobes"}, ev_q.size(), (exp_kind == K_NONE) ? 0 : 1);
      if (exp_kind != K_NONE && ev_q.size() > 0)
         check({name, " kind"}, ev_q[0].kind, exp_kind);
      check({name, " oData"}, int'(o_data), int'(exp_data));
      ev_q.delete();
   endtask

   task automatic ps2_bit(input logic b);
      @(posedge clk); #1 ps2_data = b;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      last_fe_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~(^d) ^ bad_par);
      ps2_bit(stop);
      ps2_data = 1'b1;
   endtask

   // Frame-level reference: outcome from stop bit and the odd-parity rule.
   function automatic int model_kind(input logic [7:0] d, input logic p, input logic stop);
      if (!stop) return K_FERR;
      if (($countones(d) + int'(p)) % 2 != 1) return K_PERR;
      return K_FLAG;
   endfunction

   logic [7:0] model_data;

   initial begin
      vecs[0] = '{8'h1C, 1'b0, 1'b1, K_FLAG, 8'h1C};
      vecs[1] = '{8'hF0, 1'b0, 1'b1, K_FLAG, 8'hF0};
      vecs[2] = '{8'h1C, 1'b0, 1'b1, K_FLAG, 8'h1C};
      vecs[3] = '{8'h15, 1'b1, 1'b1, K_PERR, 8'h1C};
      vecs[4] = '{8'h23, 1'b0, 1'b0, K_FERR, 8'h1C};

      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      rst      = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset oData", int'(o_data), 0);
      check("reset oFlag", int'(o_flag), 0);
      check("reset oParityErr", int'(o_perr), 0);
      check("reset oFrameErr", int'(o_ferr), 0);
      ev_q.delete();

      // Directed table, sent back to back with no idle gap.
      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop);
         check_outcome($sformatf("vec%0d", i), vecs[i].exp_kind, vecs[i].exp_data);
      end

      // PS/2 clock stalls high after 4 data bits.
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (250) @(posedge clk);
      @(negedge clk);
      check("timeout strobes", ev_q.size(), 1);
      if (ev_q.size() > 0) begin
         check("timeout kind", ev_q[0].kind, K_FERR);
         check("timeout delay in window",
               int'((ev_q[0].at - last_fe_cyc) >= 195 && (ev_q[0].at - last_fe_cyc) <= 215), 1);
      end
      check("timeout oData", int'(o_data), 8'h1C);
      ev_q.delete();
      send_frame(8'h2B, 1'b0, 1'b1);
      check_outcome("after timeout", K_FLAG, 8'h2B);

      // Reset pulse in the middle of a frame.
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      ps2_data = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check_outcome("mid-frame reset", K_NONE, 8'h00);
      send_frame(8'h1A, 1'b0, 1'b1);
      check_outcome("after reset", K_FLAG, 8'h1A);

      // Lone falling edge with data high is a glitch.
      ps2_bit(1'b1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check_outcome("lone fe", K_NONE, 8'h1A);

      // Random frames against the frame-level model.
      model_data = 8'h1A;
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         logic       bad, stop;
         int         r, k;
         d    = 8'($urandom);
         r    = $urandom_range(0, 9);
         bad  = (r == 1);
         stop = (r != 0);
         k    = model_kind(d, ~(^d) ^ bad, stop);
         if (k == K_FLAG) model_data = d;
         send_frame(d, bad, stop);
         check_outcome($sformatf("rand%0d", n), k, model_data);
         repeat ($urandom_range(0, 40)) @(posedge clk);
      end

      check("strobe width one cycle", width_viol, 0);
      check("strobes mutually exclusive", onehot_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
